keep_one_in_n_unzip: RTL and testbench
======================================

# keep_one_in_n_unzip

Expands each packed 32-bit word into four 32-bit sc16 samples, one byte per sample, and emits them in the lane order used by the packing stage. It sits directly downstream of the 4:1 byte-packing stage in the QPSK RFNoC chain, or on the receive side where packed words arrive. It restores one sample per beat for the sc16 processing blocks that follow. Full throughput is one input word per four output beats, with a single-word holding register and AXI-Stream backpressure on both sides.

## Interface
- WIDTH, 32, data width of input and output buses. Only 32 is supported.
- FILL, 0, value of the low 8 bits of the I field. Q[15:0] is always 0.
- clk  in  1  single clock domain.
- reset  in  1  synchronous, active-low reset. 0 resets the block on a rising clk edge.
- i_tdata  in  WIDTH  packed word carrying four 8-bit symbols.
- i_tlast  in  1  end-of-packet on the input word.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  WIDTH  expanded sample: {byte, FILL[7:0], 16'h0000}.
- o_tlast  out  1  end-of-packet on the output sample.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.

## Operation
- State: hold_word[31:0], hold_last, hold_valid, lane counter cnt[1:0].
- Two states, derived from hold_valid:
  - EMPTY (hold_valid=0).
  - EMIT (hold_valid=1).
- EMPTY: i_tready=1.
  - On i_tvalid, latch i_tdata into hold_word and i_tlast into hold_last.
  - Set hold_valid=1 and cnt=0, then go to EMIT.
- EMIT: o_tvalid=1. The sample byte is selected by cnt:
  - cnt 0: hold_word[23:16].
  - cnt 1: hold_word[31:24].
  - cnt 2: hold_word[7:0].
  - cnt 3: hold_word[15:8].
- o_tdata = {sel_byte, FILL[7:0], 16'h0000}. The byte is not sign-extended; it already sits in the MSBs of I.
- o_tlast = hold_last & (cnt==3). Beats 0 to 2 never carry tlast.
- On an o_tvalid&o_tready handshake with cnt<3: cnt increments.
- On an o_tvalid&o_tready handshake with cnt==3:
  - i_tready=1 in the same cycle, combinationally: i_tready = ~hold_valid | (o_tready & cnt==3).
  - If i_tvalid=1, load the new word, keep hold_valid=1, set cnt=0, and stay in EMIT (back-to-back words).
  - Otherwise clear hold_valid and return to EMPTY.
- o_tready=0 in EMIT: hold_word, cnt and o_tdata stay frozen. o_tvalid is never withdrawn.
- i_tready never depends on i_tvalid.

## Timing
- All registers are updated on the rising clk edge only.
- Reset (reset=0):
  - hold_valid=0, hold_last=0, cnt=0, hold_word=0.
  - Outputs during reset: o_tvalid=0, o_tlast=0, o_tdata=0, i_tready=0 (gated by reset).
- Reset asserted mid-word: the remaining lanes are discarded. No partial tlast is emitted.
- First cycle after release: i_tready=1.
- Latency: a word accepted at edge t gives sample 0 valid in cycle t+1. This is a registered output.
- Throughput with o_tready held high: four output beats per word, with no bubble between words if the next word is valid at the cnt==3 handshake.
- Input acceptance: at most one word per four output handshakes.
- Packet word counts are arbitrary, including a 1-word packet. Every input tlast maps to exactly one output tlast, four beats later in sample order.

## Test plan
- Single word 0xAABBCCDD, tlast=1, o_tready=1 → beats 0xBB000000, 0xAA000000, 0xDD000000, 0xCC000000. tlast only on beat 4; first beat valid 1 cycle after acceptance.
- Two back-to-back words 0x11223344 and 0x55667788 (tlast on the second), i_tvalid held high → 8 consecutive beats with no idle cycle: 22, 11, 44, 33, 66, 55, 88, 77 in [31:24]. i_tready high only in the cnt==3 handshake cycle; one tlast, on beat 8.
- Random o_tready stalls (50%) over a 64-word packet → 256 beats in order, o_tdata stable while stalled, exactly one tlast. Compare against a model of the packing stage run in reverse.
- FILL=8'h80, word 0x01020304 → beats 0x02800000, 0x01800000, 0x04800000, 0x03800000.
- Reset driven low after beat 2 of a word, then released → no further output from that word. o_tvalid=0 and i_tready=0 during reset; i_tready=1 on the first cycle after release; the next word starts at lane [23:16].
- Loopback: the packing stage feeds this block with 4N sc16 samples → output byte [31:24] equals the input I[15:8] for every sample, and tlast positions are preserved.

Source files
------------

// File: rtl/keep_one_in_n_unzip_if.sv
// keep_one_in_n_unzip_if: AXI-Stream bus bundle (data, last, valid/ready handshake).
interface keep_one_in_n_unzip_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] tdata;
    logic             tlast;
    logic             tvalid;
    logic             tready;
    modport master (output tdata, tlast, tvalid, input tready);
    modport slave  (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/keep_one_in_n_unzip.sv
// keep_one_in_n_unzip: expands each packed word into four sc16 samples, one byte per sample,
// in the lane order of the byte-packing stage.
module keep_one_in_n_unzip #(
    parameter int         WIDTH = 32,
    parameter logic [7:0] FILL  = 8'h00
) (
    input  logic clk,
    input  logic reset,
    keep_one_in_n_unzip_if.slave  s_axis,
    keep_one_in_n_unzip_if.master m_axis
);
    typedef enum logic {EMPTY, EMIT} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             last_q, last_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [7:0]       sel_byte;
    logic             emit, lane_end, out_hs, in_hs;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
            word_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        emit     = reset & (state_q == EMIT);
        lane_end = (cnt_q == 2'd3);
        // Lane order mirrors the packer: I-bytes of samples 0..3 sit at [23:16],[31:24],[7:0],[15:8]
        sel_byte = (cnt_q == 2'd0) ? word_q[23:16] :
                   (cnt_q == 2'd1) ? word_q[31:24] :
                   (cnt_q == 2'd2) ? word_q[7:0]   : word_q[15:8];
        m_axis.tvalid = emit;
        m_axis.tdata  = emit ? {sel_byte, FILL, 16'h0000} : '0;
        m_axis.tlast  = emit & last_q & lane_end;
        s_axis.tready = reset & ((state_q == EMPTY) | (m_axis.tready & lane_end));
        out_hs = emit & m_axis.tready;
        in_hs  = s_axis.tready & s_axis.tvalid;
        if (out_hs) begin
            cnt_d   = lane_end ? 2'd0 : cnt_q + 2'd1;
            state_d = lane_end ? EMPTY : EMIT;
        end
        // A word arriving on the final-lane handshake keeps the stream bubble-free
        if (in_hs) begin
            word_d  = s_axis.tdata;
            last_d  = s_axis.tlast;
            cnt_d   = 2'd0;
            state_d = EMIT;
        end
    end
endmodule

// File: tb/tb_keep_one_in_n_unzip.sv
// tb_keep_one_in_n_unzip: directed self-checking bench for the 1:4 byte unzip block.
module tb_keep_one_in_n_unzip;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keep_one_in_n_unzip_if #(.WIDTH(32)) in_if ();
    keep_one_in_n_unzip_if #(.WIDTH(32)) out_if ();
    keep_one_in_n_unzip_if #(.WIDTH(32)) in2_if ();
    keep_one_in_n_unzip_if #(.WIDTH(32)) out2_if ();

    keep_one_in_n_unzip #(.WIDTH(32), .FILL(8'h00)) dut (
        .clk(clk), .reset(reset), .s_axis(in_if.slave), .m_axis(out_if.master));
    keep_one_in_n_unzip #(.WIDTH(32), .FILL(8'h80)) dut_fill (
        .clk(clk), .reset(reset), .s_axis(in2_if.slave), .m_axis(out2_if.master));

    task automatic test_reset();
        in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tlast = 1'b0; out_if.tready = 1'b1;
        in2_if.tvalid = 1'b0; in2_if.tdata = '0; in2_if.tlast = 1'b0; out2_if.tready = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_if.tvalid !== 1'b0 || out_if.tlast !== 1'b0 || out_if.tdata !== 32'h0) begin
            errors++; $display("FAIL reset_out got v=%b l=%b d=%h want 0 0 0", out_if.tvalid, out_if.tlast, out_if.tdata);
        end
        checks++;
        if (in_if.tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", in_if.tready); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (in_if.tready !== 1'b1) begin errors++; $display("FAIL release_tready got %b want 1", in_if.tready); end
    endtask

    task automatic test_single();
        logic [31:0] exp_d [4] = '{32'hBB000000, 32'hAA000000, 32'hDD000000, 32'hCC000000};
        @(negedge clk);
        in_if.tdata = 32'hAABBCCDD; in_if.tlast = 1'b1; in_if.tvalid = 1'b1; out_if.tready = 1'b1;
        #1;
        checks++;
        if (in_if.tready !== 1'b1 || out_if.tvalid !== 1'b0) begin
            errors++; $display("FAIL single_accept got rdy=%b v=%b want 1 0", in_if.tready, out_if.tvalid);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_if.tvalid = 1'b0;
            #1;
            checks++;
            if (out_if.tvalid !== 1'b1 || out_if.tdata !== exp_d[k] || out_if.tlast !== (k == 3) || in_if.tready !== (k == 3)) begin
                errors++;
                $display("FAIL single_beat%0d got v=%b d=%h l=%b rdy=%b want 1 %h %b %b",
                         k, out_if.tvalid, out_if.tdata, out_if.tlast, in_if.tready, exp_d[k], k == 3, k == 3);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_if.tvalid !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", out_if.tvalid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [8] = '{8'h22, 8'h11, 8'h44, 8'h33, 8'h66, 8'h55, 8'h88, 8'h77};
        @(negedge clk);
        in_if.tdata = 32'h11223344; in_if.tlast = 1'b0; in_if.tvalid = 1'b1; out_if.tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_if.tdata = 32'h55667788; in_if.tlast = 1'b1; in_if.tvalid = (k < 4);
            #1;
            checks++;
            if (out_if.tvalid !== 1'b1 || out_if.tdata !== {exp_b[k], 24'h0} || out_if.tlast !== (k == 7) ||
                in_if.tready !== (k == 3 || k == 7)) begin
                errors++;
                $display("FAIL b2b_beat%0d got v=%b d=%h l=%b rdy=%b want 1 %h %b %b", k, out_if.tvalid,
                         out_if.tdata, out_if.tlast, in_if.tready, {exp_b[k], 24'h0}, k == 7, k == 3 || k == 7);
            end
        end
        @(negedge clk);
        in_if.tvalid = 1'b0;
        #1;
        checks++;
        if (out_if.tvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", out_if.tvalid); end
    endtask

    task automatic test_fill();
        logic [31:0] exp_d [4] = '{32'h02800000, 32'h01800000, 32'h04800000, 32'h03800000};
        @(negedge clk);
        in2_if.tdata = 32'h01020304; in2_if.tlast = 1'b1; in2_if.tvalid = 1'b1; out2_if.tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in2_if.tvalid = 1'b0;
            #1;
            checks++;
            if (out2_if.tvalid !== 1'b1 || out2_if.tdata !== exp_d[k] || out2_if.tlast !== (k == 3)) begin
                errors++;
                $display("FAIL fill_beat%0d got v=%b d=%h l=%b want 1 %h %b", k, out2_if.tvalid, out2_if.tdata,
                         out2_if.tlast, exp_d[k], k == 3);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] words [64];
        logic [31:0] exp_d [256];
        logic        exp_l [256];
        logic [31:0] pdata = '0;
        bit pend = 1'b0;
        int wi = 0, bi = 0, nlast = 0;
        for (int w = 0; w < 64; w++) begin
            words[w] = $urandom;
            exp_d[4*w]   = {words[w][23:16], 24'h0};
            exp_d[4*w+1] = {words[w][31:24], 24'h0};
            exp_d[4*w+2] = {words[w][7:0],   24'h0};
            exp_d[4*w+3] = {words[w][15:8],  24'h0};
            for (int k = 0; k < 4; k++) exp_l[4*w+k] = (w == 63) && (k == 3);
        end
        for (int c = 0; c < 4000 && bi < 256; c++) begin
            @(negedge clk);
            out_if.tready = 1'($urandom_range(0, 1));
            in_if.tvalid = (wi < 64);
            in_if.tdata = words[(wi < 64) ? wi : 63];
            in_if.tlast = (wi == 63);
            #1;
            if (pend) begin
                checks++;
                if (out_if.tvalid !== 1'b1 || out_if.tdata !== pdata) begin
                    errors++; $display("FAIL stall_hold got v=%b d=%h want 1 %h", out_if.tvalid, out_if.tdata, pdata);
                end
            end
            if (out_if.tvalid === 1'b1 && out_if.tready === 1'b1) begin
                checks++;
                if (out_if.tdata !== exp_d[bi] || out_if.tlast !== exp_l[bi]) begin
                    errors++; $display("FAIL stall_beat%0d got d=%h l=%b want %h %b", bi, out_if.tdata, out_if.tlast,
                                       exp_d[bi], exp_l[bi]);
                end
                nlast += int'(out_if.tlast);
                bi++;
            end
            pend = (out_if.tvalid === 1'b1) && (out_if.tready === 1'b0);
            pdata = out_if.tdata;
            if (in_if.tvalid && in_if.tready === 1'b1) wi++;
        end
        @(negedge clk);
        in_if.tvalid = 1'b0; out_if.tready = 1'b1;
        checks++;
        if (bi !== 256) begin errors++; $display("FAIL stall_count got %0d want 256", bi); end
        checks++;
        if (nlast !== 1) begin errors++; $display("FAIL stall_tlast got %0d want 1", nlast); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_d [4] = '{32'h0B000000, 32'h0A000000, 32'h0D000000, 32'h0C000000};
        @(negedge clk);
        in_if.tdata = 32'h12345678; in_if.tlast = 1'b1; in_if.tvalid = 1'b1; out_if.tready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            in_if.tvalid = 1'b0;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (out_if.tvalid !== 1'b0 || in_if.tready !== 1'b0 || out_if.tlast !== 1'b0) begin
            errors++; $display("FAIL midreset got v=%b rdy=%b l=%b want 0 0 0", out_if.tvalid, in_if.tready, out_if.tlast);
        end
        @(negedge clk);
        reset = 1'b1;
        in_if.tdata = 32'h0A0B0C0D; in_if.tlast = 1'b0; in_if.tvalid = 1'b1;
        #1;
        checks++;
        if (out_if.tvalid !== 1'b0 || in_if.tready !== 1'b1) begin
            errors++; $display("FAIL midreset_release got v=%b rdy=%b want 0 1", out_if.tvalid, in_if.tready);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_if.tvalid = 1'b0;
            #1;
            checks++;
            if (out_if.tvalid !== 1'b1 || out_if.tdata !== exp_d[k] || out_if.tlast !== 1'b0) begin
                errors++; $display("FAIL midreset_beat%0d got v=%b d=%h l=%b want 1 %h 0", k, out_if.tvalid,
                                   out_if.tdata, out_if.tlast, exp_d[k]);
            end
        end
    endtask

    task automatic test_loopback();
        logic [31:0] samp [12];
        logic        slast [12];
        logic [31:0] words [3];
        logic        wlast [3];
        int wi = 0, bi = 0;
        for (int i = 0; i < 12; i++) begin
            samp[i] = $urandom;
            slast[i] = (i == 3) || (i == 11);
        end
        for (int w = 0; w < 3; w++) begin
            words[w] = {samp[4*w+1][31:24], samp[4*w][31:24], samp[4*w+3][31:24], samp[4*w+2][31:24]};
            wlast[w] = slast[4*w+3];
        end
        for (int c = 0; c < 200 && bi < 12; c++) begin
            @(negedge clk);
            out_if.tready = 1'b1;
            in_if.tvalid = (wi < 3);
            in_if.tdata = words[(wi < 3) ? wi : 2];
            in_if.tlast = wlast[(wi < 3) ? wi : 2];
            #1;
            if (out_if.tvalid === 1'b1) begin
                checks++;
                if (out_if.tdata !== {samp[bi][31:24], 24'h0} || out_if.tlast !== slast[bi]) begin
                    errors++; $display("FAIL loop_beat%0d got d=%h l=%b want %h %b", bi, out_if.tdata, out_if.tlast,
                                       {samp[bi][31:24], 24'h0}, slast[bi]);
                end
                bi++;
            end
            if (in_if.tvalid && in_if.tready === 1'b1) wi++;
        end
        @(negedge clk);
        in_if.tvalid = 1'b0;
        checks++;
        if (bi !== 12) begin errors++; $display("FAIL loop_count got %0d want 12", bi); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_stall();
        test_reset_mid();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
